// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequences one ALU operation at a time over valid/ready.
// Operands settle for one cycle on the ALU ports, then masked results are held.
`timescale 1ns/1ps
module alu_issue_ctrl #(
    parameter int W     = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_kind,
    input  logic [W-1:0]     req_a,
    input  logic [W-1:0]     req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [W-1:0]     alu_data1,
    output logic [W-1:0]     alu_data2,
    output logic [3:0]       alu_op,
    input  logic [W-1:0]     alu_result,
    input  logic             alu_zero,
    input  logic             alu_lt,
    input  logic             alu_gt,
    input  logic             alu_branch,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_result,
    output logic             rsp_zero,
    output logic             rsp_lt,
    output logic             rsp_gt,
    output logic             rsp_taken,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             consume;
    logic             is_branch;
    logic             ops_equal;
    logic [3:0]       op_map;
    logic [TAG_W-1:0] tag_q;

    // Translate request kind into the ALU opcode encoding.
    always_comb begin
        op_map = 4'b0000;
        case (req_kind)
            3'd0:    op_map = 4'b0000;
            3'd1:    op_map = 4'b0001;
            3'd2:    op_map = 4'b0010;
            3'd3:    op_map = 4'b0011;
            3'd4:    op_map = 4'b0100;
            3'd5:    op_map = 4'b0111;
            3'd6:    op_map = 4'b0101;
            3'd7:    op_map = 4'b0110;
            default: op_map = 4'b0000;
        endcase
    end

    // Branch ops leave result/lt/gt stale in the ALU, so decode them here.
    always_comb begin
        is_branch = (alu_op == 4'b0101) || (alu_op == 4'b0110);
        ops_equal = (alu_data1 == alu_data2);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        consume   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = rst_n;
                if (req_valid) begin
                    accept    = rst_n;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    consume   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Load ALU operands, opcode and tag on request acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_data1 <= '0;
            alu_data2 <= '0;
            alu_op    <= 4'b0000;
            tag_q     <= '0;
        end else if (accept) begin
            alu_data1 <= req_a;
            alu_data2 <= req_b;
            alu_op    <= op_map;
            tag_q     <= req_tag;
        end
    end

    // Capture masked ALU outputs at the end of the settle cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_lt     <= 1'b0;
            rsp_gt     <= 1'b0;
            rsp_taken  <= 1'b0;
            rsp_tag    <= '0;
        end else if (state == DRIVE) begin
            rsp_result <= is_branch ? '0 : alu_result;
            rsp_zero   <= is_branch ? ops_equal : alu_zero;
            rsp_lt     <= ops_equal ? 1'b0 : alu_lt;
            rsp_gt     <= ops_equal ? 1'b0 : alu_gt;
            rsp_taken  <= is_branch & alu_branch;
            rsp_tag    <= tag_q;
        end
    end

    // Count consumed responses; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count <= 16'd0;
        end else if (consume) begin
            op_count <= op_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: vector table, hand sequences and random ops vs. a model.
// A stale-output ALU stand-in exercises the response masking.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

    localparam int W     = 32;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_kind;
    logic [W-1:0]     req_a;
    logic [W-1:0]     req_b;
    logic [TAG_W-1:0] req_tag;
    logic [W-1:0]     alu_data1;
    logic [W-1:0]     alu_data2;
    logic [3:0]       alu_op;
    logic [W-1:0]     alu_result;
    logic             alu_zero;
    logic             alu_lt;
    logic             alu_gt;
    logic             alu_branch;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_result;
    logic             rsp_zero;
    logic             rsp_lt;
    logic             rsp_gt;
    logic             rsp_taken;
    logic [TAG_W-1:0] rsp_tag;
    logic [15:0]      op_count;

    alu_issue_ctrl #(.W(W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_a(req_a), .req_b(req_b),
        .req_tag(req_tag),
        .alu_data1(alu_data1), .alu_data2(alu_data2),
        .alu_op(alu_op), .alu_result(alu_result),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_gt(alu_gt),
        .alu_branch(alu_branch),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_lt(rsp_lt), .rsp_gt(rsp_gt), .rsp_taken(rsp_taken),
        .rsp_tag(rsp_tag), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // ALU stand-in: branch ops and equal operands yield junk on stale outputs.
    logic [W-1:0] junk = '0;
    logic         junkb = 1'b0;
    logic         aeq;
    always_comb begin
        aeq        = (alu_data1 == alu_data2);
        alu_result = junk;
        alu_zero   = junkb;
        alu_branch = junkb;
        alu_lt     = junkb;
        alu_gt     = ~junkb;
        case (alu_op)
            4'h0: alu_result = alu_data1 + alu_data2;
            4'h1: alu_result = alu_data1 - alu_data2;
            4'h2: alu_result = alu_data1 & alu_data2;
            4'h3: alu_result = alu_data1 | alu_data2;
            4'h4: alu_result = alu_data1 ^ alu_data2;
            4'h7: alu_result = {{(W-1){1'b0}}, alu_data1 < alu_data2};
            default: ;
        endcase
        if (alu_op != 4'h5 && alu_op != 4'h6)
            alu_zero = (alu_result == '0);
        if (alu_op == 4'h5) alu_branch = aeq;
        if (alu_op == 4'h6) alu_branch = !aeq;
        if (!aeq) begin
            alu_lt = alu_data1 < alu_data2;
            alu_gt = alu_data1 > alu_data2;
        end
    end

    typedef struct {
        logic [2:0]       kind;
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        logic [TAG_W-1:0] tag;
        logic [3:0]       op;
        logic [W-1:0]     res;
        logic             z;
        logic             lt;
        logic             gt;
        logic             tk;
    } vec_t;

    logic [3:0] opmap [8] = '{4'h0, 4'h1, 4'h2, 4'h3,
                              4'h4, 4'h7, 4'h5, 4'h6};

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] exp_cnt;
    vec_t        tbl [13];

    function automatic vec_t model(input logic [2:0] k,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic [TAG_W-1:0] t);
        vec_t v;
        v.kind = k;
        v.a    = a;
        v.b    = b;
        v.tag  = t;
        v.op   = opmap[k];
        case (k)
            3'd0:    v.res = a + b;
            3'd1:    v.res = a - b;
            3'd2:    v.res = a & b;
            3'd3:    v.res = a | b;
            3'd4:    v.res = a ^ b;
            3'd5:    v.res = (a < b) ? 1 : 0;
            default: v.res = 0;
        endcase
        v.z  = (k >= 3'd6) ? (a == b) : (v.res == 0);
        v.lt = a < b;
        v.gt = a > b;
        v.tk = (k == 3'd6) ? (a == b) :
               (k == 3'd7) ? (a != b) : 1'b0;
        return v;
    endfunction

    task automatic chk(input string nm,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_cleared(input string nm);
        chk({nm, "_req_ready"}, W'(req_ready), 0);
        chk({nm, "_rsp_valid"}, W'(rsp_valid), 0);
        chk({nm, "_rsp_result"}, rsp_result, 0);
        chk({nm, "_rsp_flags"},
            W'({rsp_zero, rsp_lt, rsp_gt, rsp_taken}), 0);
        chk({nm, "_rsp_tag"}, W'(rsp_tag), 0);
        chk({nm, "_alu_data1"}, alu_data1, 0);
        chk({nm, "_alu_data2"}, alu_data2, 0);
        chk({nm, "_alu_op"}, W'(alu_op), 0);
        chk({nm, "_op_count"}, W'(op_count), 0);
    endtask

    // Runs one op from IDLE (#1 after an edge); hold = cycles of backpressure.
    task automatic do_op(input vec_t v, input int hold);
        junk      = $urandom;
        junkb     = 1'($urandom);
        req_valid = 1'b1;
        req_kind  = v.kind;
        req_a     = v.a;
        req_b     = v.b;
        req_tag   = v.tag;
        chk("req_ready_idle", W'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("alu_op", W'(alu_op), W'(v.op));
        chk("alu_data1", alu_data1, v.a);
        chk("alu_data2", alu_data2, v.b);
        chk("req_ready_drive", W'(req_ready), 0);
        chk("rsp_valid_drive", W'(rsp_valid), 0);
        @(posedge clk); #1;
        chk("rsp_valid", W'(rsp_valid), 1);
        chk("rsp_result", rsp_result, v.res);
        chk("rsp_zero", W'(rsp_zero), W'(v.z));
        chk("rsp_lt", W'(rsp_lt), W'(v.lt));
        chk("rsp_gt", W'(rsp_gt), W'(v.gt));
        chk("rsp_taken", W'(rsp_taken), W'(v.tk));
        chk("rsp_tag", W'(rsp_tag), W'(v.tag));
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_kind  = 3'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            req_tag   = 4'($urandom);
            @(posedge clk); #1;
            chk("bp_rsp_valid", W'(rsp_valid), 1);
            chk("bp_rsp_result", rsp_result, v.res);
            chk("bp_rsp_flags",
                W'({rsp_zero, rsp_lt, rsp_gt, rsp_taken}),
                W'({v.z, v.lt, v.gt, v.tk}));
            chk("bp_rsp_tag", W'(rsp_tag), W'(v.tag));
            chk("bp_req_ready", W'(req_ready), 0);
            chk("bp_alu_data1", alu_data1, v.a);
            chk("bp_alu_data2", alu_data2, v.b);
            chk("bp_alu_op", W'(alu_op), W'(v.op));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        exp_cnt   = exp_cnt + 16'd1;
        chk("rsp_valid_done", W'(rsp_valid), 0);
        chk("req_ready_done", W'(req_ready), 1);
        chk("op_count", W'(op_count), W'(exp_cnt));
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{3'd0, 32'd5, 32'd7, 4'd3, 4'h0, 32'd12,
                    1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{3'd0, 32'd1, 32'd2, 4'd1, 4'h0, 32'd3,
                    1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{3'd1, 32'd9, 32'd9, 4'd2, 4'h1, 32'd0,
                    1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{3'd6, 32'h1234, 32'h1234, 4'd4, 4'h5, 32'd0,
                    1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{3'd7, 32'h1234, 32'h1234, 4'd5, 4'h6, 32'd0,
                    1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{3'd5, 32'd1, 32'hFFFFFFFF, 4'd6, 4'h7, 32'd1,
                    1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{3'd2, 32'hF0F0, 32'hFF00, 4'd7, 4'h2, 32'hF000,
                    1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{3'd3, 32'd0, 32'd0, 4'd8, 4'h3, 32'd0,
                    1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{3'd4, 32'hFFFFFFFF, 32'd1, 4'd9, 4'h4,
                    32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{3'd1, 32'd0, 32'd1, 4'hA, 4'h1, 32'hFFFFFFFF,
                    1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{3'd7, 32'd3, 32'd4, 4'hB, 4'h6, 32'd0,
                    1'b0, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{3'd5, 32'd5, 32'd5, 4'hC, 4'h7, 32'd0,
                    1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{3'd0, 32'hFFFFFFFF, 32'd1, 4'hD, 4'h0, 32'd0,
                    1'b1, 1'b0, 1'b1, 1'b0};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_kind  = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        exp_cnt   = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_cleared("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("req_ready_release", W'(req_ready), 1);
        chk("rsp_valid_release", W'(rsp_valid), 0);

        for (int i = 0; i < 13; i++) do_op(tbl[i], 0);

        do_op(tbl[0], 5);
        do_op(model(3'd4, 32'hAAAA5555, 32'h5555AAAA, 4'hE), 0);

        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("idle_rsp_ready_cnt", W'(op_count), W'(exp_cnt));
        chk("idle_rsp_ready_vld", W'(rsp_valid), 0);

        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            do_op(model(3'($urandom), ra, rb, 4'($urandom)),
                  $urandom_range(0, 2));
        end

        req_valid = 1'b1;
        req_kind  = 3'd0;
        req_a     = 32'd3;
        req_b     = 32'd4;
        req_tag   = 4'd5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk); #1;
        chk_cleared("rst_drive");
        rst_n   = 1'b1;
        exp_cnt = 16'd0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_drive_no_rsp", W'(rsp_valid), 0);
            chk("rst_drive_ready", W'(req_ready), 1);
        end
        do_op(tbl[6], 0);

        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        chk("cnt_preload", W'(op_count), 32'hFFFF);
        exp_cnt = 16'hFFFF;
        do_op(tbl[1], 0);
        chk("cnt_wrapped", W'(op_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
